// File: rtl/collatz_sequencer.sv
// -----------------------------------------------------------------------------
// collatz_sequencer
//
// Multi-cycle Collatz orbit engine. A start request loads a BITS-wide operand,
// then one Collatz step is taken per clock until the orbit reaches 1, the
// operand is zero, the next 3n+1 would not fit in BITS bits, or the step
// budget MAX_STEPS is used up. The result registers hold their values from
// the DONE cycle until the next accepted start.
//
// Parameters:
//   BITS       width of the operand, orbit_len and path_record
//   MAX_STEPS  step budget (1 .. 2^BITS-1); reaching it aborts with timeout
//
// Ports:
//   clk          in   1     rising-edge clock
//   reset        in   1     synchronous, active-high reset
//   start        in   1     run request, sampled only in IDLE or DONE
//   number       in   BITS  start value, captured when start is accepted
//   busy         out  1     high while in RUN
//   done         out  1     high for the single DONE cycle
//   orbit_len    out  BITS  steps performed
//   path_record  out  BITS  largest value visited, start value included
//   status       out  2     00 ok, 01 zero input, 10 overflow, 11 timeout
// -----------------------------------------------------------------------------
module collatz_sequencer #(
   parameter int BITS      = 32,
   parameter int MAX_STEPS = 1000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BITS-1:0] number,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] orbit_len,
   output logic [BITS-1:0] path_record,
   output logic [1:0]      status
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_ZERO     = 2'b01;
   localparam logic [1:0] ST_OVERFLOW = 2'b10;
   localparam logic [1:0] ST_TIMEOUT  = 2'b11;

   localparam logic [BITS-1:0] STEP_LIMIT = BITS'(MAX_STEPS);

   state_t          state;
   state_t          state_next;
   logic [BITS-1:0] n;
   logic [1:0]      status_next;
   logic            load;
   logic            do_step;

   // 3n+1 is formed two bits wider than the operand so that any carry out of
   // the BITS-wide field is visible as overflow instead of silently wrapping.
   logic [BITS+1:0] n_triple;
   logic            triple_overflow;
   logic [BITS-1:0] n_stepped;

   assign n_triple        = {1'b0, n, 1'b0} + {2'b00, n} + (BITS+2)'(1);
   assign triple_overflow = |n_triple[BITS+1:BITS];
   assign n_stepped       = n[0] ? n_triple[BITS-1:0] : (n >> 1);

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   // Next-state and control decode. The RUN checks are an if/else chain so the
   // priority order (zero, one, budget, overflow, step) is explicit.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the case can leave one unassigned and infer a latch.
      state_next  = state;
      status_next = status;
      load        = 1'b0;
      do_step     = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_RUN;
               load       = 1'b1;
            end
         end

         S_RUN: begin
            if (n == '0) begin
               status_next = ST_ZERO;
               state_next  = S_DONE;
            end else if (n == BITS'(1)) begin
               status_next = ST_OK;
               state_next  = S_DONE;
            end else if (orbit_len == STEP_LIMIT) begin
               status_next = ST_TIMEOUT;
               state_next  = S_DONE;
            end else if (n[0] && triple_overflow) begin
               status_next = ST_OVERFLOW;
               state_next  = S_DONE;
            end else begin
               do_step = 1'b1;
            end
         end

         S_DONE: begin
            // DONE never lingers: restart directly or fall back to IDLE.
            if (start) begin
               state_next = S_RUN;
               load       = 1'b1;
            end else begin
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // NOTE: registered state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         n           <= '0;
         orbit_len   <= '0;
         path_record <= '0;
         status      <= ST_OK;
      end else begin
         state <= state_next;

         if (load) begin
            n           <= number;
            orbit_len   <= '0;
            path_record <= number;
            status      <= ST_OK;
         end else begin
            status <= status_next;
            if (do_step) begin
               n         <= n_stepped;
               orbit_len <= orbit_len + BITS'(1);
               if (n_stepped > path_record) begin
                  path_record <= n_stepped;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_collatz_sequencer.sv
// -----------------------------------------------------------------------------
// tb_collatz_sequencer
//
// Two instances share all inputs: one with the default step budget (1000) and
// one with a budget of 100, so timeout and normal completion of the same
// operand are seen side by side. Expected results come from a plain-arithmetic
// Collatz walk on 64-bit integers. Runs are chained: each new start is issued
// in the cycle where the slower instance shows done.
// -----------------------------------------------------------------------------
module tb_collatz_sequencer;

   localparam int BITS    = 32;
   localparam int MAX_A   = 1000;
   localparam int MAX_B   = 100;
   localparam int CYC_CAP = 1100;

   logic            clk;
   logic            reset;
   logic            start;
   logic [BITS-1:0] number;

   logic            busy_a, done_a, busy_b, done_b;
   logic [BITS-1:0] len_a, rec_a, len_b, rec_b;
   logic [1:0]      stat_a, stat_b;

   int tests_run;
   int tests_failed;

   typedef struct {
      longint unsigned len;
      longint unsigned rec;
      int              stat;
      int              cyc;
   } result_t;

   collatz_sequencer #(.BITS(BITS), .MAX_STEPS(MAX_A)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .number      (number),
      .busy        (busy_a),
      .done        (done_a),
      .orbit_len   (len_a),
      .path_record (rec_a),
      .status      (stat_a)
   );

   collatz_sequencer #(.BITS(BITS), .MAX_STEPS(MAX_B)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .number      (number),
      .busy        (busy_b),
      .done        (done_b),
      .orbit_len   (len_b),
      .path_record (rec_b),
      .status      (stat_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Walk the orbit with ordinary integer arithmetic. The done cycle is the
   // number of completed steps plus two (one cycle to enter RUN, one final
   // evaluation that decides to stop).
   function automatic result_t model(input longint unsigned num, input int max_steps);
      result_t         r;
      longint unsigned x;
      longint unsigned top;
      top    = (64'd1 << BITS) - 1;
      x      = num;
      r.len  = 0;
      r.rec  = num;
      r.stat = 0;
      forever begin
         if (x == 0) begin r.stat = 1; break; end
         if (x == 1) begin r.stat = 0; break; end
         if (r.len == longint'(max_steps)) begin r.stat = 3; break; end
         if ((x % 2 == 1) && (3 * x + 1 > top)) begin r.stat = 2; break; end
         x = (x % 2 == 0) ? x / 2 : 3 * x + 1;
         r.len++;
         if (x > r.rec) r.rec = x;
      end
      r.cyc = int'(r.len) + 2;
      return r;
   endfunction

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy_a"}, busy_a, 0);
      check({tag, "_done_a"}, done_a, 0);
      check({tag, "_len_a"},  len_a,  0);
      check({tag, "_rec_a"},  rec_a,  0);
      check({tag, "_stat_a"}, stat_a, 0);
      check({tag, "_busy_b"}, busy_b, 0);
      check({tag, "_done_b"}, done_b, 0);
      check({tag, "_len_b"},  len_b,  0);
      check({tag, "_rec_b"},  rec_b,  0);
      check({tag, "_stat_b"}, stat_b, 0);
   endtask

   // Called at a falling edge; that cycle is cycle 0. Returns at the falling
   // edge of the cycle in which the later of the two done pulses is visible.
   task automatic run(input logic [BITS-1:0] num);
      result_t ea, eb;
      bit      seen_a, seen_b, pulse;
      int      cyc;
      ea     = model(longint'(num), MAX_A);
      eb     = model(longint'(num), MAX_B);
      pulse  = (ea.cyc > 4) && (eb.cyc > 4);
      start  = 1'b1;
      number = num;
      seen_a = 1'b0;
      seen_b = 1'b0;
      cyc    = 0;
      while (!(seen_a && seen_b) && cyc < CYC_CAP) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start  = 1'b0;
            number = $urandom;
            check("load_busy_a", busy_a, 1);
            check("load_len_a",  len_a,  0);
            check("load_rec_a",  rec_a,  num);
            check("load_stat_a", stat_a, 0);
            check("load_busy_b", busy_b, 1);
            check("load_rec_b",  rec_b,  num);
         end
         // A start during RUN must be ignored.
         if (pulse && cyc == 3) begin
            start  = 1'b1;
            number = $urandom;
         end
         if (pulse && cyc == 4) start = 1'b0;

         if (done_a) begin
            if (seen_a) begin
               check("done_a_repeat", 1, 0);
            end else begin
               seen_a = 1'b1;
               check("cyc_a",  cyc,    ea.cyc);
               check("len_a",  len_a,  ea.len);
               check("rec_a",  rec_a,  ea.rec);
               check("stat_a", stat_a, ea.stat);
               check("busy_at_done_a", busy_a, 0);
            end
         end
         if (done_b) begin
            if (seen_b) begin
               check("done_b_repeat", 1, 0);
            end else begin
               seen_b = 1'b1;
               check("cyc_b",  cyc,    eb.cyc);
               check("len_b",  len_b,  eb.len);
               check("rec_b",  rec_b,  eb.rec);
               check("stat_b", stat_b, eb.stat);
               check("busy_at_done_b", busy_b, 0);
            end
         end
      end
      start = 1'b0;
      if (!seen_a) check("done_a_timeout", 0, 1);
      if (!seen_b) check("done_b_timeout", 0, 1);
   endtask

   // Reset in cycle 50 of a run on 27, together with a start that must be lost.
   task automatic reset_mid_run();
      @(negedge clk);
      start  = 1'b1;
      number = 32'd27;
      for (int c = 1; c <= 51; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 50) begin
            check("mid_busy_a", busy_a, 1);
            check("mid_busy_b", busy_b, 1);
            reset  = 1'b1;
            start  = 1'b1;
            number = 32'd6;
         end
      end
      check_idle_zero("after_reset");
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_idle_zero("after_reset_idle");
   endtask

   initial begin
      logic [BITS-1:0] v;
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      start        = 1'b0;
      number       = '0;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Directed operands; consecutive calls make back-to-back starts.
      run(32'd1);
      run(32'd6);
      run(32'd27);
      run(32'd7);
      run(32'd0);
      run(32'hFFFF_FFFF);
      run(32'h8000_0000);
      run(32'h5555_5555);
      @(negedge clk);

      // Randomized operands from three ranges.
      for (int i = 0; i < 24; i++) begin
         case (i % 3)
            0:       v = BITS'($urandom_range(2, 100000));
            1:       v = $urandom;
            default: v = 32'hFFFF_F000 | BITS'($urandom_range(0, 4095));
         endcase
         run(v);
         if (i % 4 == 0) repeat (2) @(negedge clk);
      end

      reset_mid_run();
      run(32'd27);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
